// File: rtl/recurrence_engine.sv
// Four-register recurrence engine: per iteration, sequential mode takes 4 cycles and parallel mode 1 cycle.
// No backpressure: start is sampled only in IDLE and ignored while a run is in flight.
module recurrence_engine #(
  parameter int WIDTH  = 32,
  parameter int ITER_W = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    mode,
  input  logic [ITER_W-1:0]       iter,
  input  logic signed [WIDTH-1:0] a_in,
  input  logic signed [WIDTH-1:0] b_in,
  input  logic signed [WIDTH-1:0] c_in,
  input  logic signed [WIDTH-1:0] d_in,
  output logic signed [WIDTH-1:0] a,
  output logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] c,
  output logic signed [WIDTH-1:0] d,
  output logic                    busy,
  output logic                    done,
  output logic [1:0]              phase
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state, state_n;
  logic                mode_r;
  logic [ITER_W-1:0]   count;
  logic                last_step;

  // An iteration completes on phase 3 in sequential mode and on every edge in parallel mode.
  assign last_step = (count == ITER_W'(1)) && (mode_r || (phase == 2'd3));

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (start) state_n = (iter != '0) ? RUN : DONE;
      RUN:  if (last_step) state_n = DONE;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      busy  <= (state_n == RUN);
      done  <= (state_n == DONE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a      <= '0;
      b      <= '0;
      c      <= '0;
      d      <= '0;
      mode_r <= 1'b0;
      count  <= '0;
      phase  <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a      <= a_in;
            b      <= b_in;
            c      <= c_in;
            d      <= d_in;
            mode_r <= mode;
            count  <= iter;
            phase  <= 2'd0;
          end
        end
        RUN: begin
          if (mode_r) begin
            // All right-hand sides read pre-edge values.
            a     <= b + c;
            d     <= a - WIDTH'(3);
            b     <= d + WIDTH'(10);
            c     <= c + WIDTH'(1);
            count <= count - ITER_W'(1);
          end else begin
            // One register per edge, so later phases see earlier phases' results.
            case (phase)
              2'd0: a <= b + c;
              2'd1: d <= a - WIDTH'(3);
              2'd2: b <= d + WIDTH'(10);
              default: begin
                c     <= c + WIDTH'(1);
                count <= count - ITER_W'(1);
              end
            endcase
            phase <= phase + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_recurrence_engine.sv
// Directed bench for recurrence_engine: sequential, parallel, zero-count, wrap, reset abort, start re-arm.
module tb_recurrence_engine;

  logic               clk;
  logic               rst;
  logic               start;
  logic               mode;
  logic [3:0]         iter;
  logic signed [31:0] a_in, b_in, c_in, d_in;
  logic signed [31:0] a, b, c, d;
  logic               busy, done;
  logic [1:0]         phase;

  logic              start8;
  logic signed [7:0] a8_in, b8_in, c8_in, d8_in;
  logic signed [7:0] a8, b8, c8, d8;
  logic              busy8, done8;
  logic [1:0]        phase8;

  int passed;
  int total;

  recurrence_engine #(.WIDTH(32), .ITER_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .iter(iter),
    .a_in(a_in), .b_in(b_in), .c_in(c_in), .d_in(d_in),
    .a(a), .b(b), .c(c), .d(d),
    .busy(busy), .done(done), .phase(phase)
  );

  recurrence_engine #(.WIDTH(8), .ITER_W(4)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .mode(1'b1), .iter(4'd1),
    .a_in(a8_in), .b_in(b8_in), .c_in(c8_in), .d_in(d8_in),
    .a(a8), .b(b8), .c(c8), .d(d8),
    .busy(busy8), .done(done8), .phase(phase8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic m, input logic [3:0] n,
                           input logic signed [31:0] av, input logic signed [31:0] bv,
                           input logic signed [31:0] cv, input logic signed [31:0] dv);
    mode = m; iter = n; a_in = av; b_in = bv; c_in = cv; d_in = dv;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; mode = 1'b0; iter = '0;
    a_in = 0; b_in = 0; c_in = 0; d_in = 0;
    start8 = 1'b0; a8_in = 0; b8_in = 0; c8_in = 0; d8_in = 0;
    #1;
    total++;
    if ({a, b, c, d, busy, done, phase} !== 132'd0)
      $display("FAIL reset_outputs got %h exp 0", {a, b, c, d, busy, done, phase});
    else passed++;
    #11 rst = 1'b0;
    tick();
    total++;
    if ({busy, done} !== 2'b00) $display("FAIL reset_idle got %b exp 00", {busy, done});
    else passed++;
  endtask

  task automatic test_seq_single();
    int busy_cnt;
    busy_cnt = 0;
    start_run(1'b0, 4'd1, 30, 20, 15, 5);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick();
      if (busy) busy_cnt++;
      total++;
      if (phase !== k[1:0]) $display("FAIL seq1_phase edge %0d got %0d exp %0d", k, phase, k);
      else passed++;
    end
    tick();
    if (busy) busy_cnt++;
    total++;
    if ({a, b, c, d} !== {32'd35, 32'd42, 32'd16, 32'd32})
      $display("FAIL seq1_vals got %0d %0d %0d %0d exp 35 42 16 32", a, b, c, d);
    else passed++;
    total++;
    if ({busy, done} !== 2'b01) $display("FAIL seq1_done got busy/done %b exp 01", {busy, done});
    else passed++;
    tick();
    total++;
    if ({busy, done} !== 2'b00) $display("FAIL seq1_pulse got busy/done %b exp 00", {busy, done});
    else passed++;
    total++;
    if (busy_cnt !== 4) $display("FAIL seq1_busy_cycles got %0d exp 4", busy_cnt);
    else passed++;
    total++;
    if ({a, b, c, d} !== {32'd35, 32'd42, 32'd16, 32'd32})
      $display("FAIL seq1_hold got %0d %0d %0d %0d exp 35 42 16 32", a, b, c, d);
    else passed++;
  endtask

  task automatic test_seq_multi();
    start_run(1'b0, 4'd4, 30, 20, 15, 5);
    // Inputs scrambled after the start edge must not disturb the run.
    mode = 1'b1; iter = 4'd15; a_in = -7; b_in = 99; c_in = 1000; d_in = -1;
    repeat (8) tick();
    total++;
    if ({a, b, c, d} !== {32'd58, 32'd65, 32'd17, 32'd55})
      $display("FAIL seq4_mid got %0d %0d %0d %0d exp 58 65 17 55", a, b, c, d);
    else passed++;
    repeat (7) tick();
    total++;
    if ({busy, done} !== 2'b10) $display("FAIL seq4_edge15 got busy/done %b exp 10", {busy, done});
    else passed++;
    tick();
    total++;
    if ({a, b, c, d} !== {32'd107, 32'd114, 32'd19, 32'd104})
      $display("FAIL seq4_final got %0d %0d %0d %0d exp 107 114 19 104", a, b, c, d);
    else passed++;
    total++;
    if ({busy, done} !== 2'b01) $display("FAIL seq4_done got busy/done %b exp 01", {busy, done});
    else passed++;
    tick();
  endtask

  task automatic test_parallel();
    start_run(1'b1, 4'd2, 30, 20, 15, 5);
    tick();
    total++;
    if ({a, b, c, d} !== {32'd35, 32'd15, 32'd16, 32'd27})
      $display("FAIL par_edge1 got %0d %0d %0d %0d exp 35 15 16 27", a, b, c, d);
    else passed++;
    total++;
    if ({busy, done, phase} !== 4'b1000) $display("FAIL par_busy got busy/done/phase %b exp 1000", {busy, done, phase});
    else passed++;
    tick();
    total++;
    if ({a, b, c, d} !== {32'd31, 32'd37, 32'd17, 32'd32})
      $display("FAIL par_edge2 got %0d %0d %0d %0d exp 31 37 17 32", a, b, c, d);
    else passed++;
    total++;
    if ({busy, done} !== 2'b01) $display("FAIL par_done got busy/done %b exp 01", {busy, done});
    else passed++;
    tick();
    total++;
    if ({busy, done} !== 2'b00) $display("FAIL par_idle got busy/done %b exp 00", {busy, done});
    else passed++;
  endtask

  task automatic test_zero_iter();
    for (int m = 0; m < 2; m++) begin
      start_run(m[0], 4'd0, 30, 20, 15, 5);
      total++;
      if ({busy, done} !== 2'b01) $display("FAIL zero_done mode %0d got busy/done %b exp 01", m, {busy, done});
      else passed++;
      total++;
      if ({a, b, c, d} !== {32'd30, 32'd20, 32'd15, 32'd5})
        $display("FAIL zero_vals mode %0d got %0d %0d %0d %0d exp 30 20 15 5", m, a, b, c, d);
      else passed++;
      tick();
      total++;
      if ({busy, done} !== 2'b00) $display("FAIL zero_idle mode %0d got busy/done %b exp 00", m, {busy, done});
      else passed++;
    end
  endtask

  task automatic test_wrap();
    a8_in = 8'sd0; b8_in = 8'sd127; c8_in = 8'sd127; d8_in = 8'sd0;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick();
    total++;
    if ({a8, c8} !== {8'hFE, 8'h80}) $display("FAIL wrap8 got a=%0d c=%0d exp a=-2 c=-128", a8, c8);
    else passed++;
    total++;
    if ({b8, d8, done8} !== {8'd10, 8'hFD, 1'b1})
      $display("FAIL wrap8_bd got b=%0d d=%0d done=%b exp b=10 d=-3 done=1", b8, d8, done8);
    else passed++;
    tick();
  endtask

  task automatic test_reset_mid_run();
    int done_seen;
    done_seen = 0;
    start_run(1'b0, 4'd4, 30, 20, 15, 5);
    tick(); tick();
    start = 1'b1; a_in = 1; b_in = 2; c_in = 3; d_in = 4;
    repeat (3) tick();
    total++;
    if ({a, b, c, d, phase} !== {32'd58, 32'd42, 32'd16, 32'd32, 2'd1})
      $display("FAIL abort_edge5 got %0d %0d %0d %0d ph %0d exp 58 42 16 32 ph 1", a, b, c, d, phase);
    else passed++;
    start = 1'b0;
    tick();
    #1 rst = 1'b1;
    #1;
    total++;
    if ({a, b, c, d, busy, done, phase} !== 132'd0)
      $display("FAIL abort_async got %h exp 0", {a, b, c, d, busy, done, phase});
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done || busy) done_seen++;
    end
    total++;
    if (done_seen !== 0) $display("FAIL abort_quiet got %0d active cycles exp 0", done_seen);
    else passed++;
    start_run(1'b0, 4'd1, 30, 20, 15, 5);
    repeat (4) tick();
    total++;
    if ({a, b, c, d, done} !== {32'd35, 32'd42, 32'd16, 32'd32, 1'b1})
      $display("FAIL abort_rerun got %0d %0d %0d %0d done %b exp 35 42 16 32 done 1", a, b, c, d, done);
    else passed++;
    tick();
  endtask

  task automatic test_back_to_back();
    mode = 1'b1; iter = 4'd1; a_in = 30; b_in = 20; c_in = 15; d_in = 5;
    start = 1'b1;
    tick();
    a_in = 1; b_in = 2; c_in = 3; d_in = 4;
    tick();
    total++;
    if ({a, b, c, d, done} !== {32'd35, 32'd15, 32'd16, 32'd27, 1'b1})
      $display("FAIL b2b_first got %0d %0d %0d %0d done %b exp 35 15 16 27 done 1", a, b, c, d, done);
    else passed++;
    tick();
    total++;
    if ({a, b, c, d, busy, done} !== {32'd35, 32'd15, 32'd16, 32'd27, 2'b00})
      $display("FAIL b2b_ignored got %0d %0d %0d %0d busy/done %b%b exp 35 15 16 27 00", a, b, c, d, busy, done);
    else passed++;
    tick();
    start = 1'b0;
    total++;
    if ({a, b, c, d, busy} !== {32'd1, 32'd2, 32'd3, 32'd4, 1'b1})
      $display("FAIL b2b_reload got %0d %0d %0d %0d busy %b exp 1 2 3 4 busy 1", a, b, c, d, busy);
    else passed++;
    tick(); tick();
  endtask

  initial begin
    passed = 0;
    total  = 0;
    test_reset();
    test_seq_single();
    test_seq_multi();
    test_parallel();
    test_zero_iter();
    test_wrap();
    test_reset_mid_run();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
